store_lane_unit: RTL and testbench
==================================

# store_lane_unit

Store-side memory access unit for the MIPS datapath; it does the inverse of load-side sign/zero extension. It accepts a store request (sb/sh/sw) carrying a 32-bit register value and a byte address. It narrows and replicates the value onto the correct byte lanes of a word-aligned data-memory port with byte enables. It then runs a valid/ack handshake with memory, with misalignment detection and an ack timeout.

## Interface
- ACK_TIMEOUT, default 255: cycles to wait for mem_ack before aborting; legal range 1..1023.
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  2  00=sb, 01=sh, 10=sw, 11=illegal.
- req_addr  in  32  byte address.
- req_data  in  32  register value; only the low 8 or 16 bits are used for sb and sh.
- mem_en  out  1  memory write request, held high until ack.
- mem_we  out  4  byte enables; bit i drives byte lane i (little-endian).
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory write complete.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  misaligned or illegal op; qualified by done_valid.
- done_timeout  out  1  ack timeout; qualified by done_valid.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture op, addr and data.
  - If the request is misaligned or illegal, go to RESP with err=1. Memory is never touched.
  - Otherwise go to WAIT.
- Misaligned means: sh with addr[0]=1, or sw with addr[1:0]≠0. Op 11 is illegal.
- Lane generation (little-endian):
  - sb: wdata={4{data[7:0]}}, we=4'b0001<<addr[1:0].
  - sh: wdata={2{data[15:0]}}, we=addr[1]?4'b1100:4'b0011.
  - sw: wdata=data, we=4'b1111.
- WAIT: mem_en=1, and mem_we, mem_addr and mem_wdata are held stable from the captured request.
  - Timeout counter starts at 0 on entry and increments each WAIT cycle without ack.
  - mem_ack=1 → RESP, timeout=0.
  - Counter reaching ACK_TIMEOUT-1 with no ack → RESP, timeout=1.
  - If ack arrives in the same cycle the counter reaches ACK_TIMEOUT-1, ack wins and timeout=0.
- RESP: done_valid=1 for exactly one cycle with the latched err/timeout flags, then IDLE.
- Outside WAIT: mem_en=0 and mem_we=0. mem_addr and mem_wdata are don't-care but registered; they hold their last value.
- mem_ack outside WAIT is ignored.
- A new request can be accepted in the cycle after RESP, because req_ready returns in IDLE.

## Timing
- Reset values: state=IDLE, req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, done_valid=0, done_err=0, done_timeout=0, counter=0.
- All outputs are registered or decoded from state. There is no combinational path from req_* or mem_ack to any output.
- Accept edge at cycle 0 → mem_en high in cycle 1.
- Ack sampled in cycle k (k≥1) → done_valid in cycle k+1 → req_ready in cycle k+2.
- Best-case store: done at cycle 2, next accept at cycle 3.
- Misaligned/illegal: done_valid with err in cycle 1, no mem_en at any time; next accept at cycle 2.
- Timeout: mem_en is high for exactly ACK_TIMEOUT cycles, then done_valid with timeout=1.
- resetn asserted at any point, including mid-WAIT: immediate asynchronous return to reset values. mem_en drops without waiting for ack, and no done pulse is produced for the aborted store.

## Structure
- Shared package mem_pkg holds:
  - op encodings OP_SB/OP_SH/OP_SW;
  - state encoding;
  - the WE_* lane-mask constants.
- The load-side extend unit reuses the same op encodings from this package.
- Sub-module store_lane_gen (combinational) takes op, addr[1:0] and data, and produces we, wdata and misalign.
- The top-level module holds the FSM, the capture registers and the timeout counter.

## Test plan
- sb, addr 0x1003, data 0x12345678, ack in cycle 1 → mem_addr 0x1000, mem_we 4'b1000, mem_wdata 0x78787878, done_valid in cycle 2 with err=0 and timeout=0.
- sh, addr 0x2002, data 0xFFFFABCD, ack delayed to cycle 4 → mem_en high for cycles 1–4 with outputs stable, we 4'b1100, wdata 0xABCDABCD, done_valid in cycle 5.
- sw at addr 0x0005, and sh at 0x0001 → done_err=1 in cycle 1, mem_en never asserted. op 11 at any address → same response.
- ACK_TIMEOUT=4, no ack → mem_en high in cycles 1–4, done_valid with timeout=1 in cycle 5. Repeat with ack in cycle 4 → timeout=0.
- Back-to-back sw 0x10 then sb 0x11 with req_valid held high → second accept exactly one cycle after the first done_valid. mem_ack pulses in IDLE have no effect.
- resetn low in the middle of WAIT → mem_en=0 and req_ready=1 immediately, no done_valid. Resume with a normal sw → completes correctly.

Source files
------------

// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
// Memory-access definitions shared by the load-side extend unit and the store-side lane unit.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_SB  = 2'b00,
    OP_SH  = 2'b01,
    OP_SW  = 2'b10,
    OP_ILL = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } st_e;

  // Byte-lane write masks, bit i = byte lane i (little-endian)
  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_B0   = 4'b0001;
  localparam logic [3:0] WE_LO   = 4'b0011;
  localparam logic [3:0] WE_HI   = 4'b1100;
  localparam logic [3:0] WE_ALL  = 4'b1111;

  localparam int TO_CNT_W = 10;

endpackage

// File: rtl/store_lane_gen.sv
`timescale 1ns/1ps
// Combinational lane steering for stores: replicates the narrowed value across the word
// and derives the byte enables and the alignment fault for the requested access size.
module store_lane_gen
  import mem_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  always_comb begin
    o_we       = WE_NONE;
    o_wdata    = i_data;
    o_misalign = 1'b0;
    case (i_op)
      OP_SB: begin
        o_we    = WE_B0 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      OP_SH: begin
        o_we       = i_addr_lo[1] ? WE_HI : WE_LO;
        o_wdata    = {2{i_data[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      OP_SW: begin
        o_we       = WE_ALL;
        o_misalign = |i_addr_lo;
      end
      default: begin
        o_we = WE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/store_lane_unit.sv
`timescale 1ns/1ps
// Store-side memory access unit: captures a store, presents lane-steered data to memory
// under a valid/ack handshake with an ack timeout, and reports one completion pulse.
module store_lane_unit
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        done_valid,
  output logic        done_err,
  output logic        done_timeout
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ACK_TIMEOUT - 1);

  st_e                 r_state;
  st_e                 w_next;
  mem_op_e             w_op;
  logic [3:0]          w_we;
  logic [31:0]         w_wdata;
  logic                w_misalign;
  logic                w_reject;
  logic                w_accept;
  logic                w_expire;
  logic [3:0]          r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_err;
  logic                r_timeout;
  logic [TO_CNT_W-1:0] r_cnt;

  assign w_op     = mem_op_e'(req_op);
  assign w_reject = w_misalign | (w_op == OP_ILL);
  assign w_accept = req_valid & (r_state == ST_IDLE);
  assign w_expire = (r_cnt == TO_LAST);

  store_lane_gen u_lane_gen (
    .i_op       (w_op),
    .i_addr_lo  (req_addr[1:0]),
    .i_data     (req_data),
    .o_we       (w_we),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Faulting requests skip memory entirely; ack takes priority over an expiring counter
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next = w_reject ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack || w_expire) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready    = (r_state == ST_IDLE);
    mem_en       = (r_state == ST_WAIT);
    mem_we       = (r_state == ST_WAIT) ? r_we : WE_NONE;
    done_valid   = (r_state == ST_RESP);
    done_err     = (r_state == ST_RESP) & r_err;
    done_timeout = (r_state == ST_RESP) & r_timeout;
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Memory-side fields only update for requests that will actually reach memory
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_we      <= WE_NONE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_err     <= w_reject;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      if (!w_reject) begin
        r_we    <= w_we;
        r_addr  <= {req_addr[31:2], 2'b00};
        r_wdata <= w_wdata;
      end
    end else if ((r_state == ST_WAIT) && !mem_ack) begin
      r_cnt <= r_cnt + TO_CNT_W'(1);
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_lane_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for store_lane_unit: stimulus pushes hand-computed expectations,
// a negedge monitor compares memory-side beats and completion pulses against them.
module tb_store_lane_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        done_valid;
  logic        done_err;
  logic        done_timeout;

  always #5 clk = ~clk;

  store_lane_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .done_valid   (done_valid),
    .done_err     (done_err),
    .done_timeout (done_timeout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic err;
    logic tmo;
    int   lat;
    int   en;
    bit   has_mem;
    int   acc;
  } done_exp_t;

  mem_exp_t  mq[$];
  done_exp_t dq[$];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int en_cnt = 0;
  int last_done = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: event seen with nothing expected at t=%0t", nm, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    done_exp_t e;
    if (resetn) begin
      if (mem_en) begin
        en_cnt++;
        if (mq.size() == 0) fail_evt("unexpected_mem_en");
        else begin
          chk("mem_addr", mem_addr, mq[0].addr);
          chk("mem_we", 32'(mem_we), 32'(mq[0].we));
          chk("mem_wdata", mem_wdata, mq[0].wdata);
        end
      end else begin
        chk("mem_we_when_idle", 32'(mem_we), 32'd0);
      end
      if (done_valid) begin
        if (dq.size() == 0) fail_evt("unexpected_done");
        else begin
          e = dq.pop_front();
          chk("done_err", 32'(done_err), 32'(e.err));
          chk("done_timeout", 32'(done_timeout), 32'(e.tmo));
          chk("done_cycle", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("mem_en_cycles", 32'(en_cnt), 32'(e.en));
          if (e.has_mem && mq.size() > 0) void'(mq.pop_front());
        end
        en_cnt = 0;
        last_done = cyc;
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_evt("req_ready_wait_expired");
  endtask

  task automatic store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input int ack_c, input logic e_err, input logic e_tmo, input int e_done,
                       input logic [31:0] e_addr, input logic [3:0] e_we,
                       input logic [31:0] e_wdata, input bit hold, input bit gap_chk);
    mem_exp_t  m;
    done_exp_t d;
    wait_ready();
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    if (!e_err) begin
      m.addr  = e_addr;
      m.we    = e_we;
      m.wdata = e_wdata;
      mq.push_back(m);
    end
    @(posedge clk);
    #1;
    if (gap_chk) chk("b2b_accept_gap", 32'(cyc - 1 - last_done), 32'd1);
    d.err     = e_err;
    d.tmo     = e_tmo;
    d.lat     = e_done;
    d.en      = e_err ? 0 : ((ack_c > 0) ? ack_c : TO);
    d.has_mem = !e_err;
    d.acc     = cyc;
    dq.push_back(d);
    if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= e_done; c++) begin
      mem_ack = (c == ack_c);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_err", 32'(done_err), 32'd0);
    chk("rst_done_timeout", 32'(done_timeout), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // sb / sh basic lanes
    store(2'b00, 32'h0000_1003, 32'h1234_5678, 1, 1'b0, 1'b0, 2, 32'h0000_1000, 4'b1000, 32'h7878_7878, 1'b0, 1'b0);
    store(2'b01, 32'h0000_2002, 32'hFFFF_ABCD, 4, 1'b0, 1'b0, 5, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0);
    store(2'b00, 32'h0000_2001, 32'h0000_00A5, 2, 1'b0, 1'b0, 3, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0);
    store(2'b01, 32'h0000_2000, 32'h0000_1234, 1, 1'b0, 1'b0, 2, 32'h0000_2000, 4'b0011, 32'h1234_1234, 1'b0, 1'b0);

    // misaligned and illegal
    store(2'b10, 32'h0000_0005, 32'hAAAA_5555, 0, 1'b1, 1'b0, 1, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);
    store(2'b01, 32'h0000_0001, 32'hAAAA_5555, 0, 1'b1, 1'b0, 1, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);
    store(2'b11, 32'h0000_0100, 32'h1111_2222, 0, 1'b1, 1'b0, 1, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);
    store(2'b11, 32'h0000_0003, 32'h1111_2222, 0, 1'b1, 1'b0, 1, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);

    // ack pulses while idle are ignored
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      chk("idle_ack_ready", 32'(req_ready), 32'd1);
      chk("idle_ack_no_done", 32'(done_valid), 32'd0);
      chk("idle_ack_no_en", 32'(mem_en), 32'd0);
    end
    mem_ack = 1'b0;
    @(posedge clk);
    #1;

    // timeout, and ack on the final counted cycle
    store(2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 5, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0);
    store(2'b10, 32'h0000_0044, 32'hCAFE_F00D, 4, 1'b0, 1'b0, 5, 32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);

    // back-to-back with req_valid held
    store(2'b10, 32'h0000_0010, 32'h1122_3344, 1, 1'b0, 1'b0, 2, 32'h0000_0010, 4'b1111, 32'h1122_3344, 1'b1, 1'b0);
    store(2'b00, 32'h0000_0011, 32'h0000_00EE, 1, 1'b0, 1'b0, 2, 32'h0000_0010, 4'b0010, 32'hEEEE_EEEE, 1'b0, 1'b1);

    // reset in the middle of WAIT
    begin
      mem_exp_t m;
      wait_ready();
      req_op    = 2'b10;
      req_addr  = 32'h0000_0080;
      req_data  = 32'h55AA_55AA;
      req_valid = 1'b1;
      m.addr  = 32'h0000_0080;
      m.we    = 4'b1111;
      m.wdata = 32'h55AA_55AA;
      mq.push_back(m);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("midwait_rst_mem_en", 32'(mem_en), 32'd0);
      chk("midwait_rst_req_ready", 32'(req_ready), 32'd1);
      chk("midwait_rst_done", 32'(done_valid), 32'd0);
      chk("midwait_rst_mem_addr", mem_addr, 32'd0);
      mq.delete();
      en_cnt = 0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
    end
    store(2'b10, 32'h0000_0084, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 2, 32'h0000_0084, 4'b1111, 32'h0BAD_F00D, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("done_queue_drained", 32'(dq.size()), 32'd0);
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
